// File: rtl/evm_pkg.sv
// Shared EVM definitions: read-out FSM encoding, default tally geometry, index-width helper.
package evm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_TOTAL = 2'd2,
        ST_DONE  = 2'd3
    } evm_state_e;

    localparam int EVM_NUM_CAND = 4;
    localparam int EVM_CNT_W    = 4;

    function automatic int evm_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evm_max_tracker.sv
// Running maximum over streamed counts; lowest index wins, tie flags a repeated maximum.
// Result is one cycle behind the update strobe; clr restarts the search from zero.
module evm_max_tracker
    import evm_pkg::*;
#(
    parameter int CNT_W = EVM_CNT_W,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             upd,
    input  logic [CNT_W-1:0] val,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] win_idx,
    output logic             tie
);

    logic [CNT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic             tie_q, tie_d;

    always_comb begin
        max_d = max_q;
        win_d = win_q;
        tie_d = tie_q;
        if (clr) begin
            max_d = '0;
            win_d = '0;
            tie_d = 1'b0;
        end else if (upd) begin
            // Starting from zero means an all-zero tally reports index 0 with tie set.
            if (val > max_q) begin
                max_d = val;
                win_d = idx;
                tie_d = 1'b0;
            end else if (val == max_q) begin
                tie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= '0;
            win_q <= '0;
            tie_q <= 1'b0;
        end else begin
            max_q <= max_d;
            win_q <= win_d;
            tie_q <= tie_d;
        end
    end

    assign win_idx = win_q;
    assign tie     = tie_q;

endmodule

// File: rtl/evm_result_reader.sv
// Snapshots the vote counters on start and streams (index, count) beats, then reports winner/tie.
// First beat one cycle after start, no bubbles, beat held while out_ready low; EVM_TOTAL_BEAT_EN adds a sum beat.
module evm_result_reader
    import evm_pkg::*;
#(
    parameter int  NUM_CAND = EVM_NUM_CAND,
    parameter int  CNT_W    = EVM_CNT_W,
    localparam int IDX_W    = evm_idx_w(NUM_CAND)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CAND*CNT_W-1:0] counts_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [IDX_W-1:0]          out_idx,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          winner_idx,
    output logic                      tie
`ifdef EVM_TOTAL_BEAT_EN
    ,
    output logic                      total_sat
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    evm_state_e                         state_q, state_d;
    logic [NUM_CAND-1:0][CNT_W-1:0]     snap_q, snap_d;
    logic                               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]                   out_idx_q, out_idx_d;
    logic [CNT_W-1:0]                   out_count_q, out_count_d;
    logic                               out_last_q, out_last_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [IDX_W-1:0]                   win_out_q, win_out_d;
    logic                               tie_out_q, tie_out_d;
    logic [IDX_W-1:0]                   idx_nxt;
    logic                               fire;
    logic                               trk_clr, trk_upd;
    logic [IDX_W-1:0]                   trk_win;
    logic                               trk_tie;
`ifdef EVM_TOTAL_BEAT_EN
    localparam int ACC_W = CNT_W + IDX_W;
    logic [ACC_W-1:0]                   acc_q, acc_d;
    logic                               sat_q, sat_d;
`endif

    assign fire = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        win_out_d   = win_out_q;
        tie_out_d   = tie_out_q;
        trk_clr     = 1'b0;
        trk_upd     = 1'b0;
        idx_nxt     = out_idx_q + IDX_W'(1);
`ifdef EVM_TOTAL_BEAT_EN
        acc_d       = acc_q;
        sat_d       = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d      = counts_in;
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_count_d = counts_in[CNT_W-1:0];
                    out_last_d  = 1'b0;
                    trk_clr     = 1'b1;
`ifdef EVM_TOTAL_BEAT_EN
                    acc_d       = '0;
`endif
                end
            end
            ST_SEND: begin
                if (fire) begin
                    trk_upd = 1'b1;
`ifdef EVM_TOTAL_BEAT_EN
                    acc_d = acc_q + ACC_W'(out_count_q);
`endif
                    if (out_idx_q == LAST_IDX) begin
`ifdef EVM_TOTAL_BEAT_EN
                        state_d     = ST_TOTAL;
                        out_idx_d   = '0;
                        out_count_d = acc_d[CNT_W-1:0];
                        out_last_d  = 1'b1;
                        sat_d       = |acc_d[ACC_W-1:CNT_W];
`else
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_count_d = '0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
`endif
                    end else begin
                        out_idx_d   = idx_nxt;
                        out_count_d = snap_q[idx_nxt];
`ifdef EVM_TOTAL_BEAT_EN
                        out_last_d  = 1'b0;
`else
                        out_last_d  = (idx_nxt == LAST_IDX);
`endif
                    end
                end
            end
            ST_TOTAL: begin
                if (fire) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b0;
                    out_idx_d   = '0;
                    out_count_d = '0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
`ifdef EVM_TOTAL_BEAT_EN
                    sat_d       = 1'b0;
`endif
                end
            end
            ST_DONE: begin
                // Tracker has absorbed the final beat by now; publish and hold until the next result.
                state_d   = ST_IDLE;
                win_out_d = trk_win;
                tie_out_d = trk_tie;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_out_q   <= '0;
            tie_out_q   <= 1'b0;
`ifdef EVM_TOTAL_BEAT_EN
            acc_q       <= '0;
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_out_q   <= win_out_d;
            tie_out_q   <= tie_out_d;
`ifdef EVM_TOTAL_BEAT_EN
            acc_q       <= acc_d;
            sat_q       <= sat_d;
`endif
        end
    end

    evm_max_tracker #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_max_tracker (
        .clk     (clk),
        .reset   (reset),
        .clr     (trk_clr),
        .upd     (trk_upd),
        .val     (out_count_q),
        .idx     (out_idx_q),
        .win_idx (trk_win),
        .tie     (trk_tie)
    );

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_count  = out_count_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign winner_idx = win_out_q;
    assign tie        = tie_out_q;
`ifdef EVM_TOTAL_BEAT_EN
    assign total_sat  = sat_q;
`endif

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: table of tallies plus random tallies against a max/sum reference model.
module tb_evm_result_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] counts_in;
    logic        out_ready;
    logic        out_valid;
    logic [1:0]  out_idx;
    logic [3:0]  out_count;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [1:0]  winner_idx;
    logic        tie;
`ifdef EVM_TOTAL_BEAT_EN
    logic        total_sat;
`endif

    int n_chk = 0;
    int n_err = 0;

    evm_result_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .counts_in  (counts_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_count  (out_count),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .winner_idx (winner_idx),
        .tie        (tie)
`ifdef EVM_TOTAL_BEAT_EN
        ,
        .total_sat  (total_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: maximum over all four counts, lowest index holding it wins, tie if it occurs twice or more.
    function automatic logic [2:0] ref_result(input logic [15:0] c);
        int mx, win, n;
        mx = -1; win = 0; n = 0;
        for (int i = 0; i < 4; i++)
            if (int'(c[i*4 +: 4]) > mx) begin
                mx  = int'(c[i*4 +: 4]);
                win = i;
            end
        for (int i = 0; i < 4; i++)
            if (int'(c[i*4 +: 4]) == mx) n++;
        return {(n >= 2), 2'(win)};
    endfunction

    // One complete read-out; mode 0 ready high, 1 pattern 1,0,0, 2 random.
    task automatic run(input logic [15:0] cnt, input int mode, input logic [1:0] ewin,
                       input logic etie, input bit extra_start);
        int nb, done_cnt, done_cyc, nexp, sum;
        bit prev_stall, finished, rdy;
        logic [1:0] h_idx;
        logic [3:0] h_cnt;
        logic       h_last;
        logic [1:0] e_idx[5];
        logic [3:0] e_cnt[5];
        logic       e_last[5];
        logic       e_sat[5];
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            e_idx[i]  = 2'(i);
            e_cnt[i]  = cnt[i*4 +: 4];
            e_last[i] = 1'b0;
            e_sat[i]  = 1'b0;
            sum += 32'(cnt[i*4 +: 4]);
        end
        e_idx[4] = 2'd0; e_cnt[4] = sum[3:0]; e_last[4] = 1'b1; e_sat[4] = (sum > 15);
`ifdef EVM_TOTAL_BEAT_EN
        nexp = 5;
`else
        nexp = 4;
        e_last[3] = 1'b1;
`endif
        counts_in = cnt;
        start     = 1'b1;
        out_ready = 1'b0;
        step();
        start     = 1'b0;
        counts_in = ~cnt;
        nb = 0; done_cnt = 0; done_cyc = -1; prev_stall = 0; finished = 0;
        h_idx = '0; h_cnt = '0; h_last = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (done_cyc >= 0 && !done) begin
                start = 1'b0;
                check("busy_after_done", 32'(busy), 32'(0));
                check("winner_idx", 32'(winner_idx), 32'(ewin));
                check("tie", 32'(tie), 32'(etie));
                finished = 1;
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_stall)
                check("stall_hold", {26'(0), out_valid, out_idx, out_count, out_last},
                      {26'(0), 1'b1, h_idx, h_cnt, h_last});
            if (out_valid) begin
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = (cyc % 3 == 0);
                else                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b0;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (nb < nexp) begin
                    check("beat", {25'(0), out_idx, out_count, out_last},
                          {25'(0), e_idx[nb], e_cnt[nb], e_last[nb]});
`ifdef EVM_TOTAL_BEAT_EN
                    check("total_sat", 32'(total_sat), 32'(e_sat[nb]));
`endif
                end
                nb++;
            end
            prev_stall = out_valid && !rdy;
            h_idx = out_idx; h_cnt = out_count; h_last = out_last;
            start = extra_start && (cyc == 2 || done);
            step();
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check("finished_in_budget", 32'(finished), 32'(1));
        check("beat_count", 32'(nb), 32'(nexp));
        check("done_pulses", 32'(done_cnt), 32'(1));
        if (mode == 0) check("zero_bubble_latency", 32'(done_cyc), 32'(nexp));
        if (extra_start) begin
            step();
            check("no_restart_after_done", {30'(0), busy, out_valid}, 32'(0));
        end
    endtask

    typedef struct {
        logic [15:0] cnt;
        logic [1:0]  win;
        logic        tie;
        int          mode;
        bit          extra;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [15:0] rc;
        logic [2:0]  rr;
        tbl[0] = '{16'h5273, 2'd1, 1'b0, 0, 1'b0};
        tbl[1] = '{16'h7273, 2'd1, 1'b1, 0, 1'b0};
        tbl[2] = '{16'h0000, 2'd0, 1'b1, 0, 1'b0};
        tbl[3] = '{16'h5273, 2'd1, 1'b0, 1, 1'b0};
        tbl[4] = '{16'h5273, 2'd1, 1'b0, 0, 1'b1};
        tbl[5] = '{16'hF000, 2'd3, 1'b0, 1, 1'b0};
        tbl[6] = '{16'hFFFF, 2'd0, 1'b1, 2, 1'b1};
        tbl[7] = '{16'h01FF, 2'd0, 1'b1, 0, 1'b0};

        reset = 1'b1; start = 1'b0; counts_in = '0; out_ready = 1'b0;
        repeat (2) step();
        check("reset_outputs", {22'(0), out_valid, out_idx, out_count, out_last, busy, done, winner_idx, tie},
              32'(0));
`ifdef EVM_TOTAL_BEAT_EN
        check("reset_total_sat", 32'(total_sat), 32'(0));
`endif
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            run(tbl[i].cnt, tbl[i].mode, tbl[i].win, tbl[i].tie, tbl[i].extra);

`ifdef EVM_TOTAL_BEAT_EN
        run(16'h4321, 0, 2'd3, 1'b0, 1'b0);
`endif

        // Abort mid read-out: reset after two beats, then a fresh read-out must start at index 0.
        counts_in = 16'h7273; start = 1'b1; step();
        start = 1'b0; out_ready = 1'b1;
        step(); step();
        check("pre_abort_idx", 32'(out_idx), 32'(2));
        #2 reset = 1'b1;
        #1;
        check("abort_outputs", {22'(0), out_valid, out_idx, out_count, out_last, busy, done, winner_idx, tie},
              32'(0));
        out_ready = 1'b0;
        step();
        check("abort_no_done", 32'(done), 32'(0));
        reset = 1'b0;
        step();
        check("idle_after_abort", {30'(0), busy, out_valid}, 32'(0));
        run(16'h5273, 0, 2'd1, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            rc = 16'($urandom);
            if (k % 4 == 0) rc[7:4] = rc[15:12];
            rr = ref_result(rc);
            run(rc, 2, rr[1:0], rr[2], 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
